wb_unit: RTL and testbench
==========================

# wb_unit

Writeback unit for the RV32I core: the producer side of the register file write port. Collects single-cycle ALU results and in-order memory load responses, formats load data (byte/halfword extract, sign/zero extend), and drives the register file's `rd_addr`/`w_val` pair every cycle. Tracks outstanding loads in a small in-order queue and exports a per-register pending mask so decode can stall on RAW/WAW against in-flight loads.

## Interface
- `LQ_DEPTH`, 2: maximum outstanding loads (power of two, 1..8).
- `clock`  in  1  core clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `alu_valid`  in  1  ALU result present this cycle.
- `alu_ready`  out  1  ALU result accepted this cycle; ALU holds result when low.
- `alu_rd`  in  5  destination register of ALU result.
- `alu_val`  in  32  ALU result value.
- `ld_req_valid`  in  1  load issued to memory this cycle.
- `ld_req_ready`  out  1  unit can track a new load.
- `ld_rd`  in  5  load destination register.
- `ld_funct3`  in  3  load type (LB 000, LH 001, LW 010, LBU 100, LHU 101).
- `ld_addr_lo`  in  2  low two bits of the load effective address.
- `mem_rsp_valid`  in  1  memory returns a 32-bit word this cycle (in issue order, no back-pressure).
- `mem_rsp_data`  in  32  aligned 32-bit word containing the loaded data.
- `rd_addr`  out  5  register file write address; 0 means no write.
- `w_val`  out  32  register file write value.
- `pending`  out  32  bit i set while a load to xi is outstanding; bit 0 always 0.
- `rsp_err`  out  1  sticky: response arrived with queue empty.

## Operation
- Load accept: `ld_req_valid && ld_req_ready` pushes {rd, funct3, addr_lo} onto queue; sets `pending[ld_rd]` unless `ld_rd`==0.
- `ld_req_ready` = queue not full (pre-pop count) AND `pending[ld_rd]`==0 (pre-clear value). Same-cycle retire of that rd does not allow accept.
- Response: `mem_rsp_valid` pops queue head, formats data, registers write of head rd; clears `pending[head rd]`.
- Formatting: LB/LBU select byte `addr_lo`; LH/LHU select halfword `addr_lo[1]` (bit 0 ignored; misalignment trapped upstream); LW whole word. LB/LH sign-extend, LBU/LHU zero-extend. Funct3 011/110/111 treated as LW.
- Arbitration: load response has priority. `alu_ready` = !`mem_rsp_valid`. ALU write with `alu_rd`==0 accepted, writes rd 0.
- Idle cycle (no accepted source): `rd_addr`=0, `w_val`=0.
- Response with queue empty: ignored (no write, rd_addr=0), `rsp_err` set until reset.
- Load to x0: queued and consumed normally; write emitted with `rd_addr`=0.
- ALU write to a register with `pending` set is performed; preventing it is decode's job.

## Timing
- Reset: `rd_addr`=0, `w_val`=0, `pending`=0, `rsp_err`=0, queue empty; `ld_req_ready`=1 cycle after reset drops (if `pending[ld_rd]`==0), `alu_ready` follows `mem_rsp_valid` combinationally. Reset mid-operation discards all queued loads; later responses flag `rsp_err`.
- `rd_addr`/`w_val` registered: source accepted in cycle N -> presented cycle N+1 -> register file updated at end of N+1 (its same-cycle rs==rd bypass covers readers in N+1).
- `pending` bit set visible cycle N+1 after accept in N; cleared visible N+1 after response in N, same cycle write presented.
- Accept and response in same cycle: both performed; count unchanged; full queue still refuses accept that cycle.
- Queue pointers wrap modulo `LQ_DEPTH`; count width clog2(LQ_DEPTH)+1.
- `ld_req_ready`, `alu_ready` combinational from state and current inputs; no other comb paths input->output.

## Structure
- Shared `rv32i_pkg`: XLEN=32, REG_ADDR_W=5, load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
- Sub-module `wb_load_fmt`: combinational {funct3, addr_lo, word} -> 32-bit result; unit-testable alone.
- Queue implemented inline (register array + head/tail/count).

## Test plan
- Reset then ALU {rd=5, val=0x1234_5678}, no load -> cycle+1 rd_addr=5, w_val=0x1234_5678; next idle -> rd_addr=0.
- LB rd=10 addr_lo=3, rsp 0x80FF_0000 -> w_val=0xFFFF_FF80, pending[10] 1 then 0; LBU same -> 0x0000_0080; LH addr_lo=2 rsp 0x8001_0000 -> 0xFFFF_8001.
- Two loads rd=6, rd=7 issued back-to-back (LQ_DEPTH=2) -> third refused (ld_req_ready=0); responses 0xA, 0xB write x6=0xA then x7=0xB in order.
- ALU valid with mem_rsp_valid same cycle -> alu_ready=0, load written first; ALU written following cycle.
- Load rd=6 outstanding, second load rd=6 -> refused until response cycle passed; response with empty queue -> rsp_err=1, rd_addr=0.
- Reset with 2 loads queued -> pending=0, queue empty, next response sets rsp_err.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and the load-queue entry payload used by the writeback unit.
package rv32i_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned FUNCT3_W   = 3;
  localparam int unsigned ADDR_LO_W  = 2;

  localparam logic [FUNCT3_W-1:0] F3_LB  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_LH  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_LW  = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_LBU = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [FUNCT3_W-1:0]   funct3;
    logic [ADDR_LO_W-1:0]  addr_lo;
  } ld_entry_t;

endpackage

// File: rtl/wb_unit_if.sv
// Writeback unit bus: ALU result, load issue, memory response and register-file write side.
interface wb_unit_if;
  import rv32i_pkg::*;

  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_val;
  logic                  ld_req_valid;
  logic                  ld_req_ready;
  logic [REG_ADDR_W-1:0] ld_rd;
  logic [FUNCT3_W-1:0]   ld_funct3;
  logic [ADDR_LO_W-1:0]  ld_addr_lo;
  logic                  mem_rsp_valid;
  logic [XLEN-1:0]       mem_rsp_data;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic [XLEN-1:0]       w_val;
  logic [NUM_REGS-1:0]   pending;
  logic                  rsp_err;

  modport master (
    output alu_valid, alu_rd, alu_val,
    output ld_req_valid, ld_rd, ld_funct3, ld_addr_lo,
    output mem_rsp_valid, mem_rsp_data,
    input  alu_ready, ld_req_ready, rd_addr, w_val, pending, rsp_err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_val,
    input  ld_req_valid, ld_rd, ld_funct3, ld_addr_lo,
    input  mem_rsp_valid, mem_rsp_data,
    output alu_ready, ld_req_ready, rd_addr, w_val, pending, rsp_err
  );
endinterface

// File: rtl/wb_load_fmt.sv
// Load data formatter: extracts byte/halfword from an aligned word and sign/zero extends.
module wb_load_fmt
  import rv32i_pkg::*;
(
  input  logic [FUNCT3_W-1:0]  funct3,
  input  logic [ADDR_LO_W-1:0] addr_lo,
  input  logic [XLEN-1:0]      word,
  output logic [XLEN-1:0]      result_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword select ignores addr_lo[0]; misaligned halfwords never reach here.
  always_comb begin
    byte_sel = word[7:0];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    result_c = word;
    case (addr_lo)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    case (funct3)
      F3_LB:   result_c = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   result_c = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LBU:  result_c = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  result_c = {{(XLEN-16){1'b0}}, half_sel};
      default: result_c = word;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback unit: arbitrates load responses over ALU results onto the register-file write
// port and tracks in-flight loads in an in-order queue with a per-register pending mask.
module wb_unit
  import rv32i_pkg::*;
#(
  parameter int unsigned LQ_DEPTH = 2
) (
  input  logic      clock,
  input  logic      reset,
  wb_unit_if.slave  bus
);

  localparam int unsigned PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(LQ_DEPTH) + 1;

  ld_entry_t             lq [LQ_DEPTH];
  ld_entry_t             head_ent;
  ld_entry_t             new_ent;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic [NUM_REGS-1:0]   pending_q;
  logic [NUM_REGS-1:0]   pending_d;
  logic [REG_ADDR_W-1:0] rd_addr_q;
  logic [REG_ADDR_W-1:0] rd_addr_d;
  logic [XLEN-1:0]       w_val_q;
  logic [XLEN-1:0]       w_val_d;
  logic [XLEN-1:0]       fmt_val;
  logic                  rsp_err_q;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  alu_take;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(LQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = (count == CNT_W'(LQ_DEPTH));
  assign empty    = (count == '0);
  assign head_ent = lq[head];
  assign new_ent  = '{rd: bus.ld_rd, funct3: bus.ld_funct3, addr_lo: bus.ld_addr_lo};

  // Readiness uses pre-pop count and pre-clear pending, so a same-cycle retire never frees a slot.
  assign bus.ld_req_ready = !full && !pending_q[bus.ld_rd];
  assign bus.alu_ready    = !bus.mem_rsp_valid;

  assign push     = bus.ld_req_valid && bus.ld_req_ready;
  assign pop      = bus.mem_rsp_valid && !empty;
  assign alu_take = bus.alu_valid && bus.alu_ready;

  wb_load_fmt u_fmt (
    .funct3   (head_ent.funct3),
    .addr_lo  (head_ent.addr_lo),
    .word     (bus.mem_rsp_data),
    .result_c (fmt_val)
  );

  // Next write-port value and pending mask.
  always_comb begin
    rd_addr_d = '0;
    w_val_d   = '0;
    pending_d = pending_q;
    if (pop) begin
      rd_addr_d              = head_ent.rd;
      w_val_d                = fmt_val;
      pending_d[head_ent.rd] = 1'b0;
    end else if (alu_take) begin
      rd_addr_d = bus.alu_rd;
      w_val_d   = bus.alu_val;
    end
    if (push) begin
      pending_d[bus.ld_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      pending_q <= '0;
      rd_addr_q <= '0;
      w_val_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      count     <= count + CNT_W'(push) - CNT_W'(pop);
      pending_q <= pending_d;
      rd_addr_q <= rd_addr_d;
      w_val_q   <= w_val_d;
      if (bus.mem_rsp_valid && empty) rsp_err_q <= 1'b1;
    end
  end

  // Queue storage needs no reset; entries are only read behind a valid count.
  always_ff @(posedge clock) begin
    if (push) lq[tail] <= new_ent;
  end

  assign bus.rd_addr = rd_addr_q;
  assign bus.w_val   = w_val_q;
  assign bus.pending = pending_q;
  assign bus.rsp_err = rsp_err_q;

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed scenarios plus randomized traffic against a
// queue-based reference model of the writeback rules.
module tb_wb_unit;

  localparam int unsigned DEPTH = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  wb_unit_if bus();

  wb_unit #(.LQ_DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] lo;
  } mentry_t;

  mentry_t     mq[$];
  logic [4:0]  e_rd;
  logic [31:0] e_val;
  bit          e_err;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] ref_fmt(input logic [2:0] f3, input logic [1:0] lo,
                                          input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * lo)) & 32'hFF;
    h = (w >> (16 * lo[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return b[7] ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_pending();
    logic [31:0] p = '0;
    foreach (mq[i]) if (mq[i].rd != 0) p[mq[i].rd] = 1'b1;
    return p;
  endfunction

  function automatic bit m_ld_ready();
    logic [31:0] p;
    p = m_pending();
    return (mq.size() < DEPTH) && !p[bus.ld_rd];
  endfunction

  task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] aval,
                       input bit lv, input logic [4:0] lrd, input logic [2:0] lf3,
                       input logic [1:0] llo, input bit mv, input logic [31:0] md);
    bus.alu_valid     = av;
    bus.alu_rd        = ard;
    bus.alu_val       = aval;
    bus.ld_req_valid  = lv;
    bus.ld_rd         = lrd;
    bus.ld_funct3     = lf3;
    bus.ld_addr_lo    = llo;
    bus.mem_rsp_valid = mv;
    bus.mem_rsp_data  = md;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance the model by one clock using the current inputs, then take the edge.
  task automatic tick();
    bit      take_ld;
    mentry_t ent;
    if (reset) begin
      mq.delete();
      e_err = 0; e_rd = 0; e_val = 0;
    end else begin
      take_ld = bus.ld_req_valid && m_ld_ready();
      e_rd = 0; e_val = 0;
      if (bus.mem_rsp_valid) begin
        if (mq.size() == 0) e_err = 1;
        else begin
          ent = mq.pop_front();
          e_rd = ent.rd;
          e_val = ref_fmt(ent.f3, ent.lo, bus.mem_rsp_data);
        end
      end else if (bus.alu_valid) begin
        e_rd = bus.alu_rd;
        e_val = bus.alu_val;
      end
      if (take_ld) begin
        ent.rd = bus.ld_rd; ent.f3 = bus.ld_funct3; ent.lo = bus.ld_addr_lo;
        mq.push_back(ent);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    checks++; if (bus.rd_addr !== 5'd0) begin errors++; $display("FAIL reset_rd_addr got %0d want 0", bus.rd_addr); end
    checks++; if (bus.w_val !== 32'd0) begin errors++; $display("FAIL reset_w_val got %h want 0", bus.w_val); end
    checks++; if (bus.pending !== 32'd0) begin errors++; $display("FAIL reset_pending got %h want 0", bus.pending); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", bus.rsp_err); end
    reset = 1'b0;
    #1;
    checks++; if (bus.ld_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready got %b want 1", bus.ld_req_ready); end
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready got %b want 1", bus.alu_ready); end
  endtask

  task automatic test_alu();
    drive(1, 5'd5, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
    tick();
    checks++; if (bus.rd_addr !== 5'd5) begin errors++; $display("FAIL alu_rd got %0d want 5", bus.rd_addr); end
    checks++; if (bus.w_val !== 32'h1234_5678) begin errors++; $display("FAIL alu_val got %h want 12345678", bus.w_val); end
    idle();
    tick();
    checks++; if (bus.rd_addr !== 5'd0 || bus.w_val !== 32'd0) begin errors++; $display("FAIL alu_idle got rd=%0d val=%h want 0/0", bus.rd_addr, bus.w_val); end
  endtask

  task automatic test_load_format();
    logic [2:0]  f3s  [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b001, 3'b011};
    logic [1:0]  los  [8] = '{2'd3, 2'd3, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd1};
    logic [31:0] data [8] = '{32'h80FF_0000, 32'h80FF_0000, 32'h8001_0000, 32'h8001_0000,
                              32'hDEAD_BEEF, 32'h0000_7F00, 32'h1234_F00D, 32'hCAFE_F00D};
    logic [31:0] want [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001,
                              32'hDEAD_BEEF, 32'h0000_007F, 32'hFFFF_F00D, 32'hCAFE_F00D};
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 1, 5'd10, f3s[i], los[i], 0, 0);
      tick();
      idle();
      checks++; if (bus.pending[10] !== 1'b1) begin errors++; $display("FAIL fmt%0d_pend_set got %b want 1", i, bus.pending[10]); end
      drive(0, 0, 0, 0, 0, 0, 0, 1, data[i]);
      tick();
      checks++; if (bus.rd_addr !== 5'd10 || bus.w_val !== want[i]) begin errors++; $display("FAIL fmt%0d got rd=%0d val=%h want rd=10 val=%h", i, bus.rd_addr, bus.w_val, want[i]); end
      checks++; if (bus.pending[10] !== 1'b0) begin errors++; $display("FAIL fmt%0d_pend_clr got %b want 0", i, bus.pending[10]); end
    end
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 0, 1, 5'd6, 3'b010, 0, 0, 0);
    checks++; if (bus.ld_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_first_ready got %b want 1", bus.ld_req_ready); end
    tick();
    drive(0, 0, 0, 1, 5'd7, 3'b010, 0, 0, 0);
    checks++; if (bus.ld_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_second_ready got %b want 1", bus.ld_req_ready); end
    tick();
    drive(0, 0, 0, 1, 5'd8, 3'b010, 0, 0, 0);
    checks++; if (bus.ld_req_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b want 0", bus.ld_req_ready); end
    tick();
    checks++; if (bus.pending !== 32'h0000_00C0) begin errors++; $display("FAIL b2b_pending got %h want 000000c0", bus.pending); end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hA);
    tick();
    checks++; if (bus.rd_addr !== 5'd6 || bus.w_val !== 32'hA) begin errors++; $display("FAIL b2b_rsp1 got rd=%0d val=%h want 6/a", bus.rd_addr, bus.w_val); end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hB);
    tick();
    checks++; if (bus.rd_addr !== 5'd7 || bus.w_val !== 32'hB) begin errors++; $display("FAIL b2b_rsp2 got rd=%0d val=%h want 7/b", bus.rd_addr, bus.w_val); end
    checks++; if (bus.pending !== 32'd0) begin errors++; $display("FAIL b2b_drained got %h want 0", bus.pending); end
    idle();
    tick();
  endtask

  task automatic test_priority();
    drive(0, 0, 0, 1, 5'd9, 3'b010, 0, 0, 0);
    tick();
    drive(1, 5'd3, 32'h55, 0, 0, 0, 0, 1, 32'h77);
    checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL prio_alu_ready got %b want 0", bus.alu_ready); end
    tick();
    checks++; if (bus.rd_addr !== 5'd9 || bus.w_val !== 32'h77) begin errors++; $display("FAIL prio_load_first got rd=%0d val=%h want 9/77", bus.rd_addr, bus.w_val); end
    drive(1, 5'd3, 32'h55, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL prio_alu_ready2 got %b want 1", bus.alu_ready); end
    tick();
    checks++; if (bus.rd_addr !== 5'd3 || bus.w_val !== 32'h55) begin errors++; $display("FAIL prio_alu_next got rd=%0d val=%h want 3/55", bus.rd_addr, bus.w_val); end
    idle();
    tick();
  endtask

  task automatic test_random();
    bit mv;
    for (int c = 0; c < 400; c++) begin
      mv = (mq.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 30) == 0);
      drive($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 1), 5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), mv, $urandom);
      checks++; if (bus.ld_req_ready !== m_ld_ready()) begin errors++; $display("FAIL rnd%0d_ld_ready got %b want %b", c, bus.ld_req_ready, m_ld_ready()); end
      checks++; if (bus.alu_ready !== !mv) begin errors++; $display("FAIL rnd%0d_alu_ready got %b want %b", c, bus.alu_ready, !mv); end
      tick();
      checks++; if (bus.rd_addr !== e_rd || bus.w_val !== e_val) begin errors++; $display("FAIL rnd%0d_write got rd=%0d val=%h want rd=%0d val=%h", c, bus.rd_addr, bus.w_val, e_rd, e_val); end
      checks++; if (bus.pending !== m_pending()) begin errors++; $display("FAIL rnd%0d_pending got %h want %h", c, bus.pending, m_pending()); end
      checks++; if (bus.rsp_err !== e_err) begin errors++; $display("FAIL rnd%0d_rsp_err got %b want %b", c, bus.rsp_err, e_err); end
    end
    for (int c = 0; c < 2 * DEPTH && mq.size() > 0; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, $urandom);
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_same_rd();
    drive(0, 0, 0, 1, 5'd6, 3'b010, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 5'd6, 3'b010, 0, 0, 0);
    checks++; if (bus.ld_req_ready !== 1'b0) begin errors++; $display("FAIL same_rd_refused got %b want 0", bus.ld_req_ready); end
    tick();
    drive(0, 0, 0, 1, 5'd6, 3'b010, 0, 1, 32'h11);
    checks++; if (bus.ld_req_ready !== 1'b0) begin errors++; $display("FAIL same_rd_retire_cycle got %b want 0", bus.ld_req_ready); end
    tick();
    checks++; if (bus.rd_addr !== 5'd6 || bus.w_val !== 32'h11) begin errors++; $display("FAIL same_rd_write got rd=%0d val=%h want 6/11", bus.rd_addr, bus.w_val); end
    drive(0, 0, 0, 1, 5'd6, 3'b010, 0, 0, 0);
    checks++; if (bus.ld_req_ready !== 1'b1) begin errors++; $display("FAIL same_rd_after got %b want 1", bus.ld_req_ready); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h22);
    tick();
    checks++; if (bus.rd_addr !== 5'd6 || bus.w_val !== 32'h22) begin errors++; $display("FAIL same_rd_write2 got rd=%0d val=%h want 6/22", bus.rd_addr, bus.w_val); end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h33);
    tick();
    checks++; if (bus.rsp_err !== 1'b1 || bus.rd_addr !== 5'd0) begin errors++; $display("FAIL empty_rsp got err=%b rd=%0d want 1/0", bus.rsp_err, bus.rd_addr); end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 0, 1, 5'd12, 3'b010, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 5'd13, 3'b010, 0, 0, 0);
    tick();
    checks++; if (bus.pending !== 32'h0000_3000) begin errors++; $display("FAIL rstmid_pending got %h want 00003000", bus.pending); end
    reset = 1'b1;
    idle();
    tick();
    checks++; if (bus.pending !== 32'd0 || bus.rsp_err !== 1'b0 || bus.rd_addr !== 5'd0) begin errors++; $display("FAIL rstmid_cleared got pend=%h err=%b rd=%0d want 0/0/0", bus.pending, bus.rsp_err, bus.rd_addr); end
    reset = 1'b0;
    drive(0, 0, 0, 0, 5'd12, 3'b010, 0, 0, 0);
    checks++; if (bus.ld_req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", bus.ld_req_ready); end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h44);
    tick();
    checks++; if (bus.rsp_err !== 1'b1 || bus.rd_addr !== 5'd0) begin errors++; $display("FAIL rstmid_stale_rsp got err=%b rd=%0d want 1/0", bus.rsp_err, bus.rd_addr); end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_format();
    test_back_to_back();
    test_priority();
    test_random();
    test_same_rd();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
